// File: rtl/tx_ila_gen_if.sv
// ILA octet stream from the lane-alignment generator toward the 8b/10b encoder and lane mux.
interface tx_ila_gen_if;
    logic [7:0] data;
    logic       is_k;
    logic       valid;
    logic       done;
    logic       busy;

    modport master (output data, output is_k, output valid, output done, output busy);
    modport slave  (input  data, input  is_k, input  valid, input  done, input  busy);
endinterface

// File: rtl/tx_ila_gen.sv
// JESD204B transmit ILA generator: /R/ ... /A/ multiframes with /Q/ plus link config in
// multiframe 1, data ramp elsewhere; one octet per clock, all outputs registered.
module tx_ila_gen #(
    parameter int unsigned OCT_CNT_W = 13,
    parameter int unsigned MF_CNT_W  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [7:0]           i_F,
    input  logic [4:0]           i_K,
    input  logic [7:0]           i_ila_multiframe_length,
    input  logic [111:0]         i_cfg,
    tx_ila_gen_if.master         o_ila,
    output logic                 o_cfg_err
);
    localparam int unsigned MLW = OCT_CNT_W + 1;

    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_Q = 8'h9C;

    typedef enum logic {StIdle, StRun} state_e;

    state_e               r_state,    w_state_nxt;
    logic [OCT_CNT_W-1:0] r_oct_cnt,  w_oct_cnt_nxt;
    logic [MF_CNT_W-1:0]  r_mf_cnt,   w_mf_cnt_nxt;
    logic [7:0]           r_ramp,     w_ramp_nxt;
    logic [OCT_CNT_W-1:0] r_oct_last, w_oct_last_nxt;
    logic [MF_CNT_W-1:0]  r_mf_last,  w_mf_last_nxt;
    logic [111:0]         r_cfg,      w_cfg_nxt;
    logic [7:0]           r_data,     w_data_nxt;
    logic                 r_is_k,     w_is_k_nxt;
    logic                 r_valid,    w_valid_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_cfg_err,  w_cfg_err_nxt;

    logic [MLW-1:0]       w_f, w_k, w_mf_len;
    logic                 w_at_oct_last, w_at_mf_last, w_in_mf1;
    logic [3:0]           w_cfg_idx;
    logic [7:0]           w_cfg_oct;

    // Full-width product: 256*32 needs OCT_CNT_W+1 bits.
    assign w_f      = MLW'(i_F) + MLW'(1);
    assign w_k      = MLW'(i_K) + MLW'(1);
    assign w_mf_len = w_f * w_k;

    assign w_at_oct_last = (r_oct_cnt == r_oct_last);
    assign w_at_mf_last  = (r_mf_cnt == r_mf_last);
    assign w_in_mf1      = (r_mf_cnt == MF_CNT_W'(1));
    assign w_cfg_idx     = r_oct_cnt[3:0] - 4'd2;

    always_comb begin
        w_cfg_oct = 8'h00;
        for (int n = 0; n < 14; n++) begin
            if (w_cfg_idx == 4'(n)) w_cfg_oct = r_cfg[8*n +: 8];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_oct_cnt_nxt  = r_oct_cnt;
        w_mf_cnt_nxt   = r_mf_cnt;
        w_ramp_nxt     = r_ramp;
        w_oct_last_nxt = r_oct_last;
        w_mf_last_nxt  = r_mf_last;
        w_cfg_nxt      = r_cfg;
        w_data_nxt     = 8'h00;
        w_is_k_nxt     = 1'b0;
        w_valid_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_busy_nxt     = 1'b0;
        w_cfg_err_nxt  = r_cfg_err;

        if (i_abort) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        w_oct_last_nxt = OCT_CNT_W'(w_mf_len - MLW'(1));
                        w_mf_last_nxt  = MF_CNT_W'(i_ila_multiframe_length);
                        w_cfg_nxt      = i_cfg;
                        if (w_mf_len < MLW'(17)) begin
                            w_cfg_err_nxt = 1'b1;
                        end else begin
                            // Octet 0 (/R/) is registered now so it appears next cycle.
                            w_cfg_err_nxt = 1'b0;
                            w_state_nxt   = StRun;
                            w_data_nxt    = K_R;
                            w_is_k_nxt    = 1'b1;
                            w_valid_nxt   = 1'b1;
                            w_busy_nxt    = 1'b1;
                            w_oct_cnt_nxt = OCT_CNT_W'(1);
                            w_mf_cnt_nxt  = '0;
                            w_ramp_nxt    = 8'd1;
                        end
                    end
                end
                StRun: begin
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_ramp_nxt  = r_ramp + 8'd1;
                    if (r_oct_cnt == '0) begin
                        w_data_nxt = K_R;
                        w_is_k_nxt = 1'b1;
                    end else if (w_at_oct_last) begin
                        w_data_nxt = K_A;
                        w_is_k_nxt = 1'b1;
                    end else if (w_in_mf1 && r_oct_cnt == OCT_CNT_W'(1)) begin
                        w_data_nxt = K_Q;
                        w_is_k_nxt = 1'b1;
                    end else if (w_in_mf1 && r_oct_cnt <= OCT_CNT_W'(15)) begin
                        w_data_nxt = w_cfg_oct;
                    end else begin
                        w_data_nxt = r_ramp;
                    end

                    if (w_at_oct_last) begin
                        w_oct_cnt_nxt = '0;
                        if (w_at_mf_last) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = StIdle;
                        end else begin
                            w_mf_cnt_nxt = r_mf_cnt + MF_CNT_W'(1);
                        end
                    end else begin
                        w_oct_cnt_nxt = r_oct_cnt + OCT_CNT_W'(1);
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_oct_cnt  <= '0;
            r_mf_cnt   <= '0;
            r_ramp     <= '0;
            r_oct_last <= '0;
            r_mf_last  <= '0;
            r_cfg      <= '0;
            r_data     <= '0;
            r_is_k     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_oct_cnt  <= w_oct_cnt_nxt;
            r_mf_cnt   <= w_mf_cnt_nxt;
            r_ramp     <= w_ramp_nxt;
            r_oct_last <= w_oct_last_nxt;
            r_mf_last  <= w_mf_last_nxt;
            r_cfg      <= w_cfg_nxt;
            r_data     <= w_data_nxt;
            r_is_k     <= w_is_k_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= w_busy_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
        end
    end

    assign o_ila.data  = r_data;
    assign o_ila.is_k  = r_is_k;
    assign o_ila.valid = r_valid;
    assign o_ila.done  = r_done;
    assign o_ila.busy  = r_busy;
    assign o_cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_tx_ila_gen.sv
// Scoreboard bench for tx_ila_gen: stimulus queues expected octets, a negedge monitor checks
// every valid octet, plus directed spot checks on captured octets.
module tb_tx_ila_gen;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start, i_abort;
    logic [7:0]   i_F;
    logic [4:0]   i_K;
    logic [7:0]   i_len;
    logic [111:0] i_cfg;
    logic         o_cfg_err;
    logic [111:0] cfg_a;

    tx_ila_gen_if bus ();

    tx_ila_gen dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_start                 (i_start),
        .i_abort                 (i_abort),
        .i_F                     (i_F),
        .i_K                     (i_K),
        .i_ila_multiframe_length (i_len),
        .i_cfg                   (i_cfg),
        .o_ila                   (bus),
        .o_cfg_err               (o_cfg_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errs   = 0;
    logic [9:0] sb [$];
    logic [9:0] cap [8192];
    int         cap_n = 0;

    // Expected {done, is_k, data} for overall octet index idx.
    function automatic logic [9:0] exp_oct(int idx, int mf_len, int nmf, logic [111:0] cfg);
        int p = idx % mf_len;
        int m = idx / mf_len;
        logic dn = (idx == mf_len * nmf - 1);
        if (p == 0)                     return {dn, 1'b1, 8'h1C};
        if (p == mf_len - 1)            return {dn, 1'b1, 8'h7C};
        if (m == 1 && p == 1)           return {dn, 1'b1, 8'h9C};
        if (m == 1 && p >= 2 && p <= 15) return {dn, 1'b0, cfg[8*(p-2) +: 8]};
        return {dn, 1'b0, 8'(idx)};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_octet got=%h (no octet expected)",
                             {bus.done, bus.is_k, bus.data});
                end else begin
                    logic [9:0] e;
                    e = sb.pop_front();
                    if ({bus.done, bus.is_k, bus.data} !== e) begin
                        errs++;
                        $display("FAIL octet[%0d] got done/k/data=%b/%b/%h want %b/%b/%h",
                                 cap_n, bus.done, bus.is_k, bus.data, e[9], e[8], e[7:0]);
                    end
                end
                checks++;
                if (bus.busy !== 1'b1) begin
                    errs++;
                    $display("FAIL busy_with_valid got=%b want=1", bus.busy);
                end
                if (cap_n < 8192) cap[cap_n] = {bus.done, bus.is_k, bus.data};
                cap_n++;
            end else if (bus.done !== 1'b0) begin
                checks++;
                errs++;
                $display("FAIL done_without_valid got=%b want=0", bus.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Pushes npush expected octets, pulses i_start, then scrambles config inputs.
    task automatic start_seq(input logic [7:0] f, input logic [4:0] k, input logic [7:0] len,
                             input int npush);
        int mfl = (int'(f) + 1) * (int'(k) + 1);
        for (int i = 0; i < npush; i++) sb.push_back(exp_oct(i, mfl, int'(len) + 1, cfg_a));
        cap_n   = 0;
        i_F     = f;
        i_K     = k;
        i_len   = len;
        i_cfg   = cfg_a;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_F     = 8'h00;
        i_K     = 5'h00;
        i_len   = 8'hFF;
        i_cfg   = '1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((sb.size() != 0 || bus.valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errs++;
            $display("FAIL %s_timeout got=%0d pending want=0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int qcnt;
        for (int n = 0; n < 14; n++) cfg_a[8*n +: 8] = 8'hA0 + 8'(n);
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_F = '0; i_K = '0; i_len = '0; i_cfg = '0;
        #12;
        chk("rst_data", 32'(bus.data), 32'h0);
        chk("rst_valid_k_done_busy", 32'({bus.valid, bus.is_k, bus.done, bus.busy}), 32'h0);
        chk("rst_cfg_err", 32'(o_cfg_err), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Scenario 1: F=2, K=16, 4 multiframes.
        start_seq(8'd1, 5'd15, 8'd3, 128);
        chk("s1_first_octet_valid", 32'(bus.valid), 32'h1);
        wait_drain("s1", 200);
        chk("s1_count", 32'(cap_n), 32'd128);
        chk("s1_oct0", 32'(cap[0]), 32'h11C);
        chk("s1_oct31", 32'(cap[31]), 32'h17C);
        chk("s1_oct32", 32'(cap[32]), 32'h11C);
        chk("s1_oct33", 32'(cap[33]), 32'h19C);
        chk("s1_oct34", 32'(cap[34]), 32'h0A0);
        chk("s1_oct47", 32'(cap[47]), 32'h0AD);
        chk("s1_oct48", 32'(cap[48]), 32'h030);
        chk("s1_oct126", 32'(cap[126]), 32'h07E);
        chk("s1_oct127", 32'(cap[127]), 32'h37C);
        chk("s1_idle_busy", 32'(bus.busy), 32'h0);

        // Scenario 2: mf_len 16 rejected, then 17 accepted.
        start_seq(8'd0, 5'd15, 8'd1, 0);
        chk("s2_cfg_err_set", 32'(o_cfg_err), 32'h1);
        chk("s2_no_valid", 32'(bus.valid), 32'h0);
        repeat (3) tick();
        chk("s2_busy_idle", 32'(bus.busy), 32'h0);
        start_seq(8'd0, 5'd16, 8'd1, 34);
        chk("s2_cfg_err_clr", 32'(o_cfg_err), 32'h0);
        wait_drain("s2", 100);
        chk("s2_count", 32'(cap_n), 32'd34);
        chk("s2_oct16", 32'(cap[16]), 32'h17C);
        chk("s2_oct33", 32'(cap[33]), 32'h37C);

        // Scenario 3: F=256, K=32, single multiframe.
        start_seq(8'd255, 5'd31, 8'd0, 8192);
        wait_drain("s3", 9000);
        chk("s3_count", 32'(cap_n), 32'd8192);
        chk("s3_oct0", 32'(cap[0]), 32'h11C);
        chk("s3_oct8191", 32'(cap[8191]), 32'h37C);
        qcnt = 0;
        for (int i = 0; i < 8192; i++) if (cap[i][8:0] == 9'h19C) qcnt++;
        chk("s3_no_q", 32'(qcnt), 32'd0);

        // Scenario 4: abort while octet 50 is presented.
        start_seq(8'd1, 5'd15, 8'd3, 51);
        repeat (50) tick();
        chk("s4_oct50_valid", 32'(bus.valid), 32'h1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("s4_valid_busy_done", 32'({bus.valid, bus.busy, bus.done}), 32'h0);
        repeat (5) tick();
        chk("s4_count", 32'(cap_n), 32'd51);
        chk("s4_sb_empty", 32'(sb.size()), 32'd0);

        // Scenario 5: start with abort, then start during RUN.
        cap_n = 0;
        i_F = 8'd1; i_K = 5'd15; i_len = 8'd3; i_cfg = cfg_a;
        i_start = 1'b1; i_abort = 1'b1;
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        chk("s5_abort_start_busy", 32'({bus.valid, bus.busy}), 32'h0);
        repeat (3) tick();
        chk("s5_no_octets", 32'(cap_n), 32'd0);
        start_seq(8'd1, 5'd15, 8'd3, 128);
        repeat (10) tick();
        i_F = 8'd0; i_K = 5'd31; i_len = 8'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_drain("s5", 200);
        chk("s5_count", 32'(cap_n), 32'd128);
        chk("s5_oct127", 32'(cap[127]), 32'h37C);

        // Scenario 6: asynchronous reset mid-sequence, then restart.
        start_seq(8'd1, 5'd15, 8'd3, 128);
        repeat (70) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("s6_rst_data", 32'(bus.data), 32'h0);
        chk("s6_rst_flags", 32'({bus.valid, bus.is_k, bus.done, bus.busy, o_cfg_err}), 32'h0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_seq(8'd1, 5'd15, 8'd3, 128);
        wait_drain("s6", 200);
        chk("s6_count", 32'(cap_n), 32'd128);
        chk("s6_oct0", 32'(cap[0]), 32'h11C);
        chk("s6_oct48", 32'(cap[48]), 32'h030);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule
